// File: rtl/dec_operand_fetch_if.sv
// ============================================================================
// Module : dec_operand_fetch_if
// Brief  : Fetch, register-file, bypass and DEC->EXE bundle for operand fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dec_operand_fetch_if #(
    parameter int XLEN   = 32,
    parameter int RADR_W = 6,
    parameter int CNT_W  = 32
);
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [4:0]        if_rs1;
    logic [4:0]        if_rs2;
    logic [4:0]        if_rd;
    logic              if_use_rs1;
    logic              if_use_rs2;
    logic              if_wen;
    logic              if_is_load;
    logic              dec_ready;

    logic [RADR_W-1:0] RADR1_SD;
    logic [RADR_W-1:0] RADR2_SD;
    logic [XLEN-1:0]   RDATA1_SR;
    logic [XLEN-1:0]   RDATA2_SR;

    logic [4:0]        exe_rd;
    logic              exe_wen;
    logic              exe_is_load;
    logic [XLEN-1:0]   exe_result;
    logic [4:0]        mem_rd;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_result;
    logic [4:0]        wb_rd;
    logic              wb_wen;
    logic [XLEN-1:0]   wb_data;
    logic              flush;

    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic [4:0]        ex_rd;
    logic              ex_wen;
    logic              ex_is_load;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  if_valid, if_pc, if_rs1, if_rs2, if_rd, if_use_rs1, if_use_rs2,
               if_wen, if_is_load, RDATA1_SR, RDATA2_SR,
               exe_rd, exe_wen, exe_is_load, exe_result,
               mem_rd, mem_wen, mem_result, wb_rd, wb_wen, wb_data,
               flush, ex_ready,
        output dec_ready, RADR1_SD, RADR2_SD,
               ex_valid, ex_pc, ex_op1, ex_op2, ex_rd, ex_wen, ex_is_load,
               stall_cnt
    );

    modport master (
        output if_valid, if_pc, if_rs1, if_rs2, if_rd, if_use_rs1, if_use_rs2,
               if_wen, if_is_load, RDATA1_SR, RDATA2_SR,
               exe_rd, exe_wen, exe_is_load, exe_result,
               mem_rd, mem_wen, mem_result, wb_rd, wb_wen, wb_data,
               flush, ex_ready,
        input  dec_ready, RADR1_SD, RADR2_SD,
               ex_valid, ex_pc, ex_op1, ex_op2, ex_rd, ex_wen, ex_is_load,
               stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/dec_operand_fetch.sv
// ============================================================================
// Module : dec_operand_fetch
// Brief  : Decode operand fetch with EXE/MEM/WB forwarding and load-use stall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dec_operand_fetch #(
    parameter int XLEN   = 32,
    parameter int RADR_W = 6,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    dec_operand_fetch_if.slave bus
);
    logic              w_advance;
    logic              w_luh;
    logic [XLEN-1:0]   op1_d;
    logic [XLEN-1:0]   op2_d;

    logic              ex_valid_q;
    logic [XLEN-1:0]   ex_pc_q;
    logic [XLEN-1:0]   ex_op1_q;
    logic [XLEN-1:0]   ex_op2_q;
    logic [4:0]        ex_rd_q;
    logic              ex_wen_q;
    logic              ex_is_load_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    // Youngest producer wins; x0 is hard-wired so it never takes a bypass.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_data,
        input logic [4:0]      e_rd,
        input logic            e_wen,
        input logic [XLEN-1:0] e_val,
        input logic [4:0]      m_rd,
        input logic            m_wen,
        input logic [XLEN-1:0] m_val,
        input logic [4:0]      w_rd,
        input logic            w_wen,
        input logic [XLEN-1:0] w_val
    );
        if (rs == 5'd0)                   return '0;
        else if (e_wen && (e_rd == rs))   return e_val;
        else if (m_wen && (m_rd == rs))   return m_val;
        else if (w_wen && (w_rd == rs))   return w_val;
        else                              return rf_data;
    endfunction

    always_comb begin
        op1_d = fwd(bus.if_rs1, bus.RDATA1_SR,
                    bus.exe_rd, bus.exe_wen, bus.exe_result,
                    bus.mem_rd, bus.mem_wen, bus.mem_result,
                    bus.wb_rd,  bus.wb_wen,  bus.wb_data);
        op2_d = fwd(bus.if_rs2, bus.RDATA2_SR,
                    bus.exe_rd, bus.exe_wen, bus.exe_result,
                    bus.mem_rd, bus.mem_wen, bus.mem_result,
                    bus.wb_rd,  bus.wb_wen,  bus.wb_data);
    end

    assign w_advance = ~ex_valid_q | bus.ex_ready;
    assign w_luh     = bus.if_valid & bus.exe_is_load & bus.exe_wen & (bus.exe_rd != 5'd0)
                     & ((bus.if_use_rs1 & (bus.exe_rd == bus.if_rs1))
                      | (bus.if_use_rs2 & (bus.exe_rd == bus.if_rs2)));

    assign bus.dec_ready = bus.flush | (w_advance & ~w_luh);
    assign bus.RADR1_SD  = {{(RADR_W-5){1'b0}}, bus.if_rs1};
    assign bus.RADR2_SD  = {{(RADR_W-5){1'b0}}, bus.if_rs2};

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_rd_q      <= '0;
            ex_wen_q     <= 1'b0;
            ex_is_load_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else if (bus.flush) begin
            ex_valid_q   <= 1'b0;
        end else if (w_advance && w_luh) begin
            ex_valid_q   <= 1'b0;
            if (stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end else if (w_advance) begin
            ex_valid_q   <= bus.if_valid;
            ex_pc_q      <= bus.if_pc;
            ex_op1_q     <= op1_d;
            ex_op2_q     <= op2_d;
            ex_rd_q      <= bus.if_rd;
            ex_wen_q     <= bus.if_valid & bus.if_wen;
            ex_is_load_q <= bus.if_valid & bus.if_is_load;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_pc      = ex_pc_q;
    assign bus.ex_op1     = ex_op1_q;
    assign bus.ex_op2     = ex_op2_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_wen     = ex_wen_q;
    assign bus.ex_is_load = ex_is_load_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_dec_operand_fetch.sv
// ============================================================================
// Module : tb_dec_operand_fetch
// Brief  : Scoreboard bench for dec_operand_fetch forwarding, stalls and flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dec_operand_fetch;
    logic clk;
    logic reset;

    dec_operand_fetch_if #(.XLEN(32), .RADR_W(6), .CNT_W(32)) bus ();

    dec_operand_fetch #(.XLEN(32), .RADR_W(6), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] rf [32];
    int          n_pass  = 0;
    int          n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.RDATA1_SR = rf[bus.RADR1_SD[4:0]];
    assign bus.RDATA2_SR = rf[bus.RADR2_SD[4:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic wen, input logic ld);
        bus.if_valid   = 1'b1;
        bus.if_pc      = pc;
        bus.if_rs1     = rs1;
        bus.if_rs2     = rs2;
        bus.if_rd      = rd;
        bus.if_use_rs1 = u1;
        bus.if_use_rs2 = u2;
        bus.if_wen     = wen;
        bus.if_is_load = ld;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [4:0] rd, input logic wen, input logic ld);
        exp_t e;
        e.pc = pc; e.op1 = op1; e.op2 = op2; e.rd = rd; e.wen = wen; e.ld = ld;
        sb_q.push_back(e);
    endtask

    task automatic clear_producers();
        bus.exe_wen = 1'b0; bus.exe_is_load = 1'b0; bus.exe_rd = '0; bus.exe_result = '0;
        bus.mem_wen = 1'b0; bus.mem_rd = '0; bus.mem_result = '0;
        bus.wb_wen  = 1'b0; bus.wb_rd  = '0; bus.wb_data    = '0;
    endtask

    // Monitor: every EXE handshake consumes the oldest expected instruction.
    always @(negedge clk) begin
        if (!reset && bus.ex_valid && bus.ex_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ex_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_pc",  bus.ex_pc,  e.pc);
                chk("sb_op1", bus.ex_op1, e.op1);
                chk("sb_op2", bus.ex_op2, e.op2);
                chk("sb_ctl", {27'd0, bus.ex_rd, bus.ex_wen, bus.ex_is_load},
                              {27'd0, e.rd, e.wen, e.ld});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        reset = 1'b1;
        bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_rs1 = '0; bus.if_rs2 = '0; bus.if_rd = '0;
        bus.if_use_rs1 = 1'b0; bus.if_use_rs2 = 1'b0; bus.if_wen = 1'b0; bus.if_is_load = 1'b0;
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        clear_producers();
        repeat (2) step();

        chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_ex_pc", bus.ex_pc, 32'd0);
        chk("rst_ex_ops", bus.ex_op1 | bus.ex_op2, 32'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
        reset = 1'b0;

        // Plain register-file read, rs2 = x0.
        rf[5] = 32'h11; rf[6] = 32'h66; rf[7] = 32'h77;
        issue(32'h100, 5'd5, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 chk("t1_dec_ready", {31'd0, bus.dec_ready}, 32'd1);
        push(32'h100, 32'h11, 32'h0, 5'd1, 1'b1, 1'b0);
        step();
        chk("t1_ex_valid", {31'd0, bus.ex_valid}, 32'd1);

        // Forwarding priority EXE > MEM > WB.
        bus.exe_rd = 5'd5; bus.exe_wen = 1'b1; bus.exe_result = 32'hAA;
        bus.mem_rd = 5'd5; bus.mem_wen = 1'b1; bus.mem_result = 32'hBB;
        bus.wb_rd  = 5'd5; bus.wb_wen  = 1'b1; bus.wb_data    = 32'hCC;
        issue(32'h104, 5'd5, 5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        push(32'h104, 32'hAA, 32'h66, 5'd2, 1'b1, 1'b0);
        step();
        bus.exe_wen = 1'b0;
        issue(32'h108, 5'd5, 5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        push(32'h108, 32'hBB, 32'h66, 5'd2, 1'b1, 1'b0);
        step();
        bus.mem_wen = 1'b0;
        issue(32'h10C, 5'd5, 5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        push(32'h10C, 32'hCC, 32'h66, 5'd2, 1'b1, 1'b0);
        step();

        // Load-use on rs2: one bubble, then MEM bypass.
        clear_producers();
        bus.exe_rd = 5'd7; bus.exe_wen = 1'b1; bus.exe_is_load = 1'b1; bus.exe_result = 32'hDEAD;
        issue(32'h110, 5'd0, 5'd7, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 chk("luh_dec_ready", {31'd0, bus.dec_ready}, 32'd0);
        step();
        chk("luh_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("luh_stall_cnt", bus.stall_cnt, 32'd1);
        clear_producers();
        bus.mem_rd = 5'd7; bus.mem_wen = 1'b1; bus.mem_result = 32'h1234;
        #1 chk("luh_release_ready", {31'd0, bus.dec_ready}, 32'd1);
        push(32'h110, 32'h0, 32'h1234, 5'd8, 1'b1, 1'b0);
        step();

        // Same dependency but rs2 unused: no stall, forwarded value still captured.
        clear_producers();
        bus.exe_rd = 5'd7; bus.exe_wen = 1'b1; bus.exe_is_load = 1'b1; bus.exe_result = 32'hDEAD;
        issue(32'h114, 5'd0, 5'd7, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 chk("nouse_dec_ready", {31'd0, bus.dec_ready}, 32'd1);
        push(32'h114, 32'h0, 32'hDEAD, 5'd9, 1'b1, 1'b1);
        step();
        chk("nouse_stall_cnt", bus.stall_cnt, 32'd1);

        // Backpressure: held payload must not track changing bypass values.
        clear_producers();
        issue(32'h118, 5'd5, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        push(32'h118, 32'h11, 32'h0, 5'd10, 1'b1, 1'b0);
        step();
        bus.ex_ready = 1'b0;
        bus.exe_rd = 5'd5; bus.exe_wen = 1'b1;
        issue(32'h11C, 5'd5, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.exe_result = 32'h55 + i;
            #1;
            chk("bp_dec_ready", {31'd0, bus.dec_ready}, 32'd0);
            chk("bp_hold_op1", bus.ex_op1, 32'h11);
            chk("bp_hold_pc", bus.ex_pc, 32'h118);
            step();
        end
        bus.ex_ready = 1'b1;
        bus.exe_result = 32'h99;
        #1 chk("bp_release_ready", {31'd0, bus.dec_ready}, 32'd1);
        push(32'h11C, 32'h99, 32'h0, 5'd11, 1'b1, 1'b0);
        step();

        // Flush beats a simultaneous load-use hazard.
        clear_producers();
        bus.exe_rd = 5'd7; bus.exe_wen = 1'b1; bus.exe_is_load = 1'b1;
        bus.flush = 1'b1;
        issue(32'h120, 5'd0, 5'd7, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 chk("flush_dec_ready", {31'd0, bus.dec_ready}, 32'd1);
        step();
        chk("flush_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("flush_stall_cnt", bus.stall_cnt, 32'd1);
        bus.flush = 1'b0;
        clear_producers();
        issue(32'h124, 5'd5, 5'd6, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        push(32'h124, 32'h11, 32'h66, 5'd3, 1'b1, 1'b0);
        step();

        // x0 ignores producers that claim to write it.
        bus.exe_rd = 5'd0; bus.exe_wen = 1'b1; bus.exe_result = 32'hFFFF_FFFF;
        bus.mem_rd = 5'd0; bus.mem_wen = 1'b1; bus.mem_result = 32'hFFFF_FFFF;
        issue(32'h128, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        push(32'h128, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);
        step();

        // Reset in the middle of a stall.
        clear_producers();
        bus.exe_rd = 5'd7; bus.exe_wen = 1'b1; bus.exe_is_load = 1'b1;
        issue(32'h12C, 5'd7, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("rst2_luh_ready", {31'd0, bus.dec_ready}, 32'd0);
        step();
        chk("rst2_stall_cnt", bus.stall_cnt, 32'd2);
        reset = 1'b1;
        step();
        chk("rst2_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst2_ex_pc", bus.ex_pc, 32'd0);
        chk("rst2_ex_ops", bus.ex_op1 | bus.ex_op2, 32'd0);
        chk("rst2_ex_ctl", {29'd0, bus.ex_rd == 5'd0 ? 1'b0 : 1'b1, bus.ex_wen, bus.ex_is_load}, 32'd0);
        chk("rst2_stall_cnt", bus.stall_cnt, 32'd0);
        reset = 1'b0;
        bus.if_valid = 1'b0;
        clear_producers();
        repeat (3) step();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/dec_operand_fetch.md
Name: dec_operand_fetch

Overview:
- Decode-stage operand fetch, directly upstream of the register file's read ports and downstream of instruction fetch.
- Drives the register-file read addresses and collects the combinational read data.
- Resolves RAW hazards by forwarding from EXE, MEM and WB, and stalls one cycle on load-use.
- Registers resolved operands into the DEC→EXE pipeline register with a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- RADR_W, 6, register-file address width; bit 5 is always 0 here.
- CNT_W, 32, width of the load-use stall counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_pc  in  XLEN  PC of the presented instruction.
- if_rs1, if_rs2, if_rd  in  5 each  decoded register indices.
- if_use_rs1, if_use_rs2  in  1 each  operand is actually read.
- if_wen  in  1  instruction writes rd.
- if_is_load  in  1  instruction is a load.
- dec_ready  out  1  instruction accepted this cycle.
- RADR1_SD, RADR2_SD  out  RADR_W  register-file read addresses = {1'b0, if_rs1}, {1'b0, if_rs2}.
- RDATA1_SR, RDATA2_SR  in  XLEN  register-file read data, combinational, same cycle.
- exe_rd  in  5, exe_wen  in  1, exe_is_load  in  1, exe_result  in  XLEN  EXE-stage producer.
- mem_rd  in  5, mem_wen  in  1, mem_result  in  XLEN  MEM-stage producer.
- wb_rd  in  5, wb_wen  in  1, wb_data  in  XLEN  value being written to the register file this edge.
- flush  in  1  redirect from EXE; kill the in-flight instruction.
- ex_valid  out  1  DEC→EXE register holds a valid instruction.
- ex_ready  in  1  EXE accepts.
- ex_pc, ex_op1, ex_op2  out  XLEN  registered PC and resolved operands.
- ex_rd  out  5, ex_wen  out  1, ex_is_load  out  1  registered control.
- stall_cnt  out  CNT_W  number of load-use bubbles inserted; saturating.

Behaviour:
- Reset (sync, dominant): ex_valid=0; ex_pc, ex_op1, ex_op2 = 0; ex_rd=0; ex_wen=0; ex_is_load=0; stall_cnt=0.
- advance = ~ex_valid | ex_ready.
- Per operand n (rsN = if_rs1 / if_rs2), forwarding priority:
  - rsN==0 → 0.
  - else exe_wen && exe_rd==rsN → exe_result.
  - else mem_wen && mem_rd==rsN → mem_result.
  - else wb_wen && wb_rd==rsN → wb_data.
  - else RDATA_N_SR.
  - An unused operand (if_use_rsN=0) still gets the forwarded value; it never causes a hazard.
- Load-use hazard: luh = if_valid & exe_is_load & exe_wen & exe_rd≠0 & ((if_use_rs1 & exe_rd==if_rs1) | (if_use_rs2 & exe_rd==if_rs2)).
- dec_ready = flush | (advance & ~luh). Accepting on flush discards the fetch slot.
- Register update each cycle, in this order:
  - flush: ex_valid←0; payload don't-care; stall_cnt unchanged.
  - else advance & luh: ex_valid←0 (bubble); stall_cnt += 1, saturating at all-ones.
  - else advance: ex_valid←if_valid; capture pc, op1, op2, rd, wen, is_load. When if_valid=0, ex_wen←0 and ex_is_load←0.
  - else (ex_valid & ~ex_ready): hold all outputs stable, including operands. No re-forwarding while held.
- Latency: an accepted instruction appears on ex_* on the next cycle.
- A load-use stall lasts exactly one cycle, because the load moves to MEM and the value is then forwarded from mem_result.
- Register x0 never forwards, even when a producer has wen=1 and rd=0.
- Simultaneous flush and luh: flush wins; no bubble is counted.
- Reset mid-stall: everything returns to reset values; the pending instruction is lost and fetch is expected to re-present.

Test Plan:
- Reset, then x5=0x11 in the register file, present rs1=5, rs2=0, no producers → next cycle ex_valid=1, ex_op1=0x11, ex_op2=0.
- EXE rd=5 result 0xAA, MEM rd=5 result 0xBB, WB rd=5 data 0xCC, all wen=1; issue rs1=5 → ex_op1=0xAA. Drop EXE → 0xBB. Drop MEM → 0xCC.
- Load-use:
  - EXE is_load=1, rd=7; present rs2=7 with use_rs2=1 → dec_ready=0, ex_valid=0 next cycle, stall_cnt=1.
  - Next cycle MEM rd=7 result 0x1234 → accepted, ex_op2=0x1234.
  - Same pattern with use_rs2=0 → no stall.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles while forwarding sources change → ex_* held constant, dec_ready=0. Release ex_ready → new instruction captured.
- flush together with luh and a valid input → dec_ready=1, ex_valid=0, stall_cnt unchanged. Next instruction flows normally.
- Producer EXE rd=0 wen=1 result 0xFFFF_FFFF; issue rs1=0 → ex_op1=0. Assert reset during a stall → all outputs 0 on the next cycle.
